// File: rtl/code_phase_search_seq_pkg.sv
// Shared types and constants for the acquisition code-phase search path.
// mod_code_len folds an 11-bit phase sum back into the 10-bit code-phase range.
package gps_acq_pkg;

  localparam int CODE_LEN = 1023;
  localparam int PHASE_W  = 10;
  localparam int SUM_W    = 32;
  localparam int ID_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Inputs are each < len, so a single conditional subtract is enough.
  function automatic logic [PHASE_W-1:0] mod_code_len(input logic [PHASE_W:0] x,
                                                      input logic [PHASE_W:0] len);
    logic [PHASE_W:0] r;
    r = (x >= len) ? (x - len) : x;
    return r[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/code_phase_search_seq_if.sv
// Sequencer <-> correlator bus: phase/start from the sequencer, one-shot result back.
interface code_phase_search_seq_if;
  import gps_acq_pkg::*;

  // corr_start is a one-cycle request to correlate at phase; phase is held
  // stable until the matching corr_done, a one-cycle pulse that qualifies
  // corr_peak_id/corr_peak_sum. There is no backpressure in either direction.
  logic [PHASE_W-1:0]       phase;
  logic                     corr_start;
  logic                     corr_done;
  logic [ID_W-1:0]          corr_peak_id;
  logic signed [SUM_W-1:0]  corr_peak_sum;

  modport master (output phase, corr_start,
                  input  corr_done, corr_peak_id, corr_peak_sum);
  modport slave  (input  phase, corr_start,
                  output corr_done, corr_peak_id, corr_peak_sum);
endinterface

// File: rtl/code_phase_search_seq_peak_tracker.sv
// Keeps the strongest |sum| seen in a sweep and the absolute code phase it came from.
// Ties keep the earlier window; the most negative sum saturates to the largest positive magnitude.
module peak_tracker
  import gps_acq_pkg::*;
#(
  parameter int CODE_LEN_P = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_en,
  input  logic [PHASE_W-1:0]      i_phase,
  input  logic [ID_W-1:0]         i_id,
  input  logic signed [SUM_W-1:0] i_sum,
  output logic [SUM_W-1:0]        o_best_mag,
  output logic [PHASE_W-1:0]      o_best_phase
);

  logic [SUM_W-1:0]   r_best_mag;
  logic [PHASE_W-1:0] r_best_phase;
  logic [SUM_W-1:0]   w_mag;
  logic [PHASE_W:0]   w_abs_phase;

  always_comb begin
    w_mag = i_sum;
    if (i_sum == {1'b1, {(SUM_W-1){1'b0}}})
      w_mag = {1'b0, {(SUM_W-1){1'b1}}};
    else if (i_sum[SUM_W-1])
      w_mag = -i_sum;
  end

  assign w_abs_phase = {1'b0, i_phase} + {{(PHASE_W+1-ID_W){1'b0}}, i_id};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_best_mag   <= '0;
      r_best_phase <= '0;
    end else if (i_en && (w_mag > r_best_mag)) begin
      r_best_mag   <= w_mag;
      r_best_phase <= mod_code_len(w_abs_phase, (PHASE_W+1)'(CODE_LEN_P));
    end
  end

  assign o_best_mag   = r_best_mag;
  assign o_best_phase = r_best_phase;

endmodule

// File: rtl/code_phase_search_seq.sv
// Steps the correlator through every code-phase window, one request at a time,
// and reports the strongest peak plus whether it cleared the detection threshold.
module code_phase_search_seq
  import gps_acq_pkg::PHASE_W, gps_acq_pkg::SUM_W, gps_acq_pkg::state_t,
         gps_acq_pkg::ST_IDLE, gps_acq_pkg::ST_ISSUE, gps_acq_pkg::ST_WAIT,
         gps_acq_pkg::ST_EVAL, gps_acq_pkg::ST_DONE, gps_acq_pkg::mod_code_len,
         gps_acq_pkg::ID_W;
#(
  parameter int          CODE_LEN = 1023,
  parameter int          STEP     = 64,
  parameter logic [31:0] THRESH   = 32'd2048,
  parameter int          TIMEOUT  = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  code_phase_search_seq_if.master corr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_found,
  output logic                    o_timeout_err,
  output logic [PHASE_W-1:0]      o_best_phase,
  output logic [SUM_W-1:0]        o_best_mag,
  output state_t                  o_dbg_state
);

  localparam int NWIN  = (CODE_LEN + STEP - 1) / STEP;
  localparam int WIN_W = $clog2(NWIN + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [PHASE_W-1:0]      r_phase;
  logic [WIN_W-1:0]        r_win;
  logic [TMR_W-1:0]        r_timer;
  logic [ID_W-1:0]         r_id;
  logic signed [SUM_W-1:0] r_sum;
  logic                    r_found;
  logic                    r_timeout_err;
  logic                    w_accept;
  logic                    w_eval_en;
  logic                    w_timeout;
  logic                    w_last_win;

  assign w_accept   = (r_state == ST_IDLE) && i_start;
  assign w_eval_en  = (r_state == ST_EVAL) && !i_abort;
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last_win = (r_win == WIN_W'(NWIN - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (corr.corr_done)  w_next = ST_EVAL;
        else if (w_timeout)  w_next = ST_DONE;
      end
      ST_EVAL:  w_next = w_last_win ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    // Abort beats everything except a start arriving while already idle.
    if (i_abort && (r_state != ST_IDLE))
      w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_win         <= '0;
      r_timer       <= '0;
      r_id          <= '0;
      r_sum         <= '0;
      r_found       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_phase       <= '0;
          r_win         <= '0;
          r_found       <= 1'b0;
          r_timeout_err <= 1'b0;
        end
        ST_ISSUE: r_timer <= '0;
        ST_WAIT: if (!i_abort) begin
          if (corr.corr_done) begin
            r_id  <= corr.corr_peak_id;
            r_sum <= corr.corr_peak_sum;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_EVAL: if (!i_abort) begin
          r_phase <= mod_code_len({1'b0, r_phase} + (PHASE_W+1)'(STEP),
                                  (PHASE_W+1)'(CODE_LEN));
          if (!w_last_win) r_win <= r_win + 1'b1;
        end
        ST_DONE: if (!i_abort) r_found <= !r_timeout_err && (o_best_mag > THRESH);
        default: ;
      endcase
    end
  end

  peak_tracker #(.CODE_LEN_P(CODE_LEN)) u_peak (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_accept),
    .i_en         (w_eval_en),
    .i_phase      (r_phase),
    .i_id         (r_id),
    .i_sum        (r_sum),
    .o_best_mag   (o_best_mag),
    .o_best_phase (o_best_phase)
  );

  assign corr.phase      = r_phase;
  assign corr.corr_start = (r_state == ST_ISSUE);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_DONE) && !i_abort;
  assign o_found         = r_found;
  assign o_timeout_err   = r_timeout_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_code_phase_search_seq.sv
// Directed bench for code_phase_search_seq with a table-driven correlator model.
module tb_code_phase_search_seq;
  import gps_acq_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        tb_abort;
  logic        model_abort;
  logic        i_abort;
  logic        o_busy, o_done, o_found, o_timeout_err;
  logic [9:0]  o_best_phase;
  logic [31:0] o_best_mag;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  int n_dones  = 0;

  logic [31:0] m_sum [16];
  logic [7:0]  m_id  [16];
  bit          m_skip[16];
  int          m_abort_win;

  code_phase_search_seq_if cif();

  assign i_abort = tb_abort | model_abort;

  code_phase_search_seq dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .corr          (cif),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_found       (o_found),
    .o_timeout_err (o_timeout_err),
    .o_best_phase  (o_best_phase),
    .o_best_mag    (o_best_mag),
    .o_dbg_state   (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // correlator model: answers 10 cycles after each request from its table
  initial begin
    int w;
    cif.corr_done     = 1'b0;
    cif.corr_peak_id  = '0;
    cif.corr_peak_sum = '0;
    model_abort       = 1'b0;
    forever begin
      @(negedge clk);
      if (cif.corr_start) begin
        w = int'(cif.phase) / 64;
        if (!m_skip[w]) begin
          repeat (9) @(negedge clk);
          cif.corr_done     = 1'b1;
          cif.corr_peak_id  = m_id[w];
          cif.corr_peak_sum = m_sum[w];
          if (w == m_abort_win) model_abort = 1'b1;
          @(negedge clk);
          cif.corr_done = 1'b0;
          model_abort   = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cif.corr_start) n_starts <= n_starts + 1;
    if (o_done)         n_dones  <= n_dones + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_table(input logic [31:0] sum, input logic [7:0] id);
    for (int i = 0; i < 16; i++) begin
      m_sum[i] = sum; m_id[i] = id; m_skip[i] = 1'b0;
    end
    m_abort_win = -1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_done) begin got = 1'b1; break; end
    end
    check("done_seen", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_phase"},  32'(cif.phase), 32'd0);
    check({tag, "_cstart"}, 32'(cif.corr_start), 32'd0);
    check({tag, "_busy"},   32'(o_busy), 32'd0);
    check({tag, "_done"},   32'(o_done), 32'd0);
    check({tag, "_found"},  32'(o_found), 32'd0);
    check({tag, "_tmo"},    32'(o_timeout_err), 32'd0);
    check({tag, "_bphase"}, 32'(o_best_phase), 32'd0);
    check({tag, "_bmag"},   o_best_mag, 32'd0);
    check({tag, "_state"},  32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int s0, d0;
    bit idle_seen;
    rst = 1'b1; i_start = 1'b0; tb_abort = 1'b0;
    set_table(32'd0, 8'd0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // nominal sweep: one strong negative peak at phase 320
    set_table(32'd100, 8'd0);
    m_id[5] = 8'd5; m_sum[5] = -32'sd5000;
    s0 = n_starts; d0 = n_dones;
    pulse_start();
    check("nom_busy", 32'(o_busy), 32'd1);
    wait_done(400);
    check("nom_starts", 32'(n_starts - s0), 32'd16);
    check("nom_dones",  32'(n_dones - d0), 32'd1);
    check("nom_found",  32'(o_found), 32'd1);
    check("nom_bphase", 32'(o_best_phase), 32'd325);
    check("nom_bmag",   o_best_mag, 32'd5000);
    check("nom_tmo",    32'(o_timeout_err), 32'd0);
    check("nom_busy_end", 32'(o_busy), 32'd0);
    check("nom_phase_end", 32'(cif.phase), 32'd1);

    // no signal: everything within +/-1000, tie at window 12 keeps window 7
    for (int i = 0; i < 16; i++) begin
      m_sum[i] = 32'($urandom_range(0, 1998)) - 32'd999;
      m_id[i]  = 8'($urandom_range(0, 255));
    end
    m_sum[7] = -32'sd1000; m_id[7] = 8'd0;
    m_sum[12] = 32'd1000;
    pulse_start();
    wait_done(400);
    check("nosig_found",  32'(o_found), 32'd0);
    check("nosig_bmag",   o_best_mag, 32'd1000);
    check("nosig_bphase", 32'(o_best_phase), 32'd448);
    check("nosig_tmo",    32'(o_timeout_err), 32'd0);

    // wrap: last window 960 + id 100 folds to 37
    set_table(32'd0, 8'd0);
    m_sum[15] = 32'd9000; m_id[15] = 8'd100;
    pulse_start();
    wait_done(400);
    check("wrap_bphase", 32'(o_best_phase), 32'd37);
    check("wrap_bmag",   o_best_mag, 32'd9000);
    check("wrap_found",  32'(o_found), 32'd1);

    // tie: window 14 (896+200 -> 73) wins over equal magnitude in window 15
    m_sum[14] = -32'sd9000; m_id[14] = 8'd200;
    pulse_start();
    wait_done(400);
    check("tie_bphase", 32'(o_best_phase), 32'd73);
    check("tie_bmag",   o_best_mag, 32'd9000);

    // timeout: window 3 never answered, strong peak earlier must not set found
    set_table(32'd0, 8'd0);
    m_sum[0] = 32'd9999; m_skip[3] = 1'b1;
    s0 = n_starts; d0 = n_dones;
    pulse_start();
    wait_done(5000);
    check("tmo_err",    32'(o_timeout_err), 32'd1);
    check("tmo_found",  32'(o_found), 32'd0);
    check("tmo_busy",   32'(o_busy), 32'd0);
    check("tmo_starts", 32'(n_starts - s0), 32'd4);
    check("tmo_dones",  32'(n_dones - d0), 32'd1);
    check("tmo_bmag",   o_best_mag, 32'd9999);

    // abort collides with corr_done of window 5; a mid-sweep start is ignored
    set_table(32'd0, 8'd0);
    m_sum[2] = 32'd3000; m_id[2] = 8'd1;
    m_sum[5] = 32'd7000; m_abort_win = 5;
    s0 = n_starts; d0 = n_dones;
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    idle_seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!o_busy) begin idle_seen = 1'b1; break; end
    end
    check("abort_idle", 32'(idle_seen), 32'd1);
    repeat (20) @(negedge clk);
    check("abort_starts", 32'(n_starts - s0), 32'd6);
    check("abort_dones",  32'(n_dones - d0), 32'd0);
    check("abort_bmag",   o_best_mag, 32'd3000);
    check("abort_bphase", 32'(o_best_phase), 32'd129);
    check("abort_found",  32'(o_found), 32'd0);
    check("abort_tmo",    32'(o_timeout_err), 32'd0);
    check("abort_state",  32'(dbg_state), 32'(ST_IDLE));
    m_abort_win = -1;

    // start and abort together while idle: start wins; then reset mid-WAIT
    i_start = 1'b1; tb_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; tb_abort = 1'b0;
    check("sa_busy",   32'(o_busy), 32'd1);
    check("sa_cstart", 32'(cif.corr_start), 32'd1);
    @(negedge clk);
    check("sa_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // saturation: -2^31 becomes 2^31-1; an equal +max later does not move the phase
    set_table(32'd0, 8'd0);
    m_sum[0] = 32'h8000_0000;
    m_sum[9] = 32'h7FFF_FFFF; m_id[9] = 8'd3;
    pulse_start();
    wait_done(400);
    check("sat_bmag",   o_best_mag, 32'h7FFF_FFFF);
    check("sat_bphase", 32'(o_best_phase), 32'd0);
    check("sat_found",  32'(o_found), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
